fir_pulse_shaper: RTL and testbench



---
 rtl/fir_pulse_shaper_if.sv | 21 ++
 rtl/fir_pulse_shaper.sv | 127 ++++++++++++
 tb/tb_fir_pulse_shaper.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fir_pulse_shaper_if.sv
// Sample stream into and filtered stream out of fir_pulse_shaper.
// master = upstream/downstream side, slave = the filter.
interface fir_pulse_shaper_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fir_pulse_shaper.sv
// Time-multiplexed symmetric FIR (31 taps, 16 folded MAC cycles per output).
// Define FIR_SATURATE_EN to clamp the rounded result instead of wrapping it.
module fir_pulse_shaper #(
  parameter  int DATA_W = 16,
  parameter  int COEF_W = 16,
  parameter  int FRAC_W = 13,
  parameter  int NTAPS  = 31,
  parameter  int ACC_W  = 38,
  localparam int NU     = (NTAPS + 1) / 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NU*COEF_W-1:0] coef_bus,
  fir_pulse_shaper_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int KW  = $clog2(NU);
  localparam int XW  = $clog2(NTAPS);
  localparam int CBW = $clog2(NU * COEF_W);
  localparam int PW  = DATA_W + COEF_W + 1;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_W - 1);

  logic [1:0]               state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [DATA_W-1:0] x_d [NTAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [DATA_W-1:0] lo, hi;
  logic signed [DATA_W:0]   pre;
  logic [CBW-1:0]           cbase;
  logic signed [COEF_W-1:0] coef;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_sum, rnd, r;
  logic [DATA_W-1:0]        res;
  logic                     rnd_unused;

  // Folded datapath: the centre tap has no mirror partner, so its second operand is zero.
  always_comb begin
    lo    = x_q[XW'(k_q)];
    hi    = (k_q == KW'(NU - 1)) ? '0 : x_q[XW'(NTAPS - 1) - XW'(k_q)];
    pre   = {lo[DATA_W-1], lo} + {hi[DATA_W-1], hi};
    cbase = CBW'(k_q) * CBW'(COEF_W);
    coef  = coef_bus[cbase +: COEF_W];
    prod  = pre * coef;
    acc_sum = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
    rnd   = acc_sum + HALF;
    r     = rnd >>> FRAC_W;
  end

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  always_comb begin
    if (r > MAXV)      res = {1'b0, {(DATA_W-1){1'b1}}};
    else if (r < MINV) res = {1'b1, {(DATA_W-1){1'b0}}};
    else               res = r[DATA_W-1:0];
  end
`else
  always_comb res = r[DATA_W-1:0];
`endif

  assign rnd_unused = ^{rnd[FRAC_W-1:0], r[ACC_W-1:DATA_W]};

  // The result is rounded off the final accumulate so out_data and out_valid align in DONE.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d[0] = bus.in_data;
          for (int unsigned i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
          acc_d   = '0;
          k_d     = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NU - 1)) begin
          out_data_d  = res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_pulse_shaper.sv
// Directed self-checking bench for fir_pulse_shaper (impulse, DC, handshake,
// saturation/wrap, rounding, reset abort); honours FIR_SATURATE_EN.
module tb_fir_pulse_shaper;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] coef_bus = '0;

  fir_pulse_shaper_if bus ();

  fir_pulse_shaper dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .coef_bus (coef_bus),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] imp [16] = '{16'hFF75, 16'hFFEE, 16'h00D0, 16'h0123,
                            16'hFF00, 16'hFE80, 16'h0050, 16'h0300,
                            16'hFD00, 16'hFC80, 16'h0400, 16'h0900,
                            16'h0E00, 16'h1500, 16'h1B00, 16'h21C1};
  logic [15:0] cur [16];
  logic [15:0] y;
  int          lat;
  int          vcount;
  logic [15:0] exp_sat1, exp_sat31, exp_neg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_coefs();
    for (int k = 0; k < 16; k++) coef_bus[k*16 +: 16] = cur[k];
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one sample in an IDLE cycle, then wait (bounded) for its result.
  task automatic feed(input logic [15:0] d, output logic [15:0] yo, output int lo);
    int n;
    chk("in_ready_before_feed", bus.in_ready, 1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    yo = bus.out_data;
    lo = n;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

`ifdef FIR_SATURATE_EN
    exp_sat1  = 16'h7FFF;
    exp_sat31 = 16'h7FFF;
    exp_neg   = 16'h8000;
`else
    exp_sat1  = 16'hFFF8;
    exp_sat31 = 16'hFF08;
    exp_neg   = 16'h0004;
`endif

    // Reset state
    do_reset();
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);

    // Impulse response reproduces the taps in order, mirrored after the centre
    cur = imp;
    load_coefs();
    for (int n = 1; n <= 31; n++) begin
      int p;
      feed((n == 1) ? 16'h2000 : 16'h0000, y, lat);
      p = n - 1;
      chk($sformatf("impulse_out%0d", n), y, imp[(p <= 15) ? p : 30 - p]);
      chk($sformatf("impulse_lat%0d", n), lat, 17);
    end

    // Reset during MAC cycle 8 aborts the sample
    bus.in_data  = 16'h1234;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #2;
    chk("abort_out_valid_in_reset", bus.out_valid, 0);
    chk("abort_out_data_in_reset", bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("abort_in_ready_after", bus.in_ready, 1);
    chk("abort_out_data_after", bus.out_data, 0);
    vcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcount++;
    end
    chk("abort_no_out_valid", vcount, 0);
    feed(16'h2000, y, lat);
    chk("abort_next_impulse_tap1", y, 16'hFF75);

    // DC gain ramps to 31 x 0x0100 and holds
    do_reset();
    for (int k = 0; k < 16; k++) cur[k] = 16'h0100;
    load_coefs();
    for (int n = 1; n <= 36; n++) begin
      feed(16'h2000, y, lat);
      chk($sformatf("dc_out%0d", n), y, ((n < 31) ? n : 31) * 256);
    end

    // Rounding: half an LSB rounds up, minus half an LSB rounds to zero
    do_reset();
    for (int k = 0; k < 16; k++) cur[k] = 16'h0000;
    cur[15] = 16'h1000;
    load_coefs();
    for (int n = 1; n <= 16; n++) begin
      feed((n == 1) ? 16'h0001 : 16'h0000, y, lat);
      if (n >= 15) chk($sformatf("round_pos_out%0d", n), y, (n == 16) ? 1 : 0);
    end
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      feed((n == 1) ? 16'hFFFF : 16'h0000, y, lat);
      if (n >= 15) chk($sformatf("round_neg_out%0d", n), y, 0);
    end

    // Saturation / wrap at the positive and negative rails
    do_reset();
    for (int k = 0; k < 16; k++) cur[k] = 16'h7FFF;
    load_coefs();
    for (int n = 1; n <= 31; n++) begin
      feed(16'h7FFF, y, lat);
      if (n == 1)  chk("sat_out1", y, exp_sat1);
      if (n == 31) chk("sat_out31", y, exp_sat31);
    end
    do_reset();
    feed(16'h8000, y, lat);
    chk("sat_neg_out1", y, exp_neg);

    // Handshake: in_valid held high, data changes every cycle
    do_reset();
    for (int k = 0; k < 16; k++) cur[k] = 16'h0000;
    cur[0] = 16'h2000;
    load_coefs();
    bus.in_valid = 1'b1;
    for (int c = 0; c < 54; c++) begin
      bus.in_data = 16'h0100 + 16'(c);
      chk($sformatf("hs_ready_c%0d", c), bus.in_ready, ((c % 18) == 0) ? 1 : 0);
      chk($sformatf("hs_valid_c%0d", c), bus.out_valid, ((c % 18) == 17) ? 1 : 0);
      if ((c % 18) == 17) chk($sformatf("hs_data_c%0d", c), bus.out_data, 16'h0100 + 16'(c - 17));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
